// File: rtl/router_pkg.sv
// router_pkg
// Shared constants for the router datapath (router_reg, router FSM and
// router_fifo): payload width, FIFO depth, where the packet length lives
// inside a header byte, and the width of the per-packet byte counter.
// No ports; imported with `import router_pkg::*;`.
package router_pkg;

    localparam int ROUTER_DATA_W  = 8;
    localparam int ROUTER_DEPTH   = 16;

    // Header byte layout: [7:2] payload length, [1:0] destination address.
    localparam int HDR_LEN_MSB    = 7;
    localparam int HDR_LEN_LSB    = 2;
    localparam int HDR_LEN_W      = HDR_LEN_MSB - HDR_LEN_LSB + 1;

    // Counter must hold payload length + 1 parity byte (max 64).
    localparam int BYTE_CNT_W     = 7;

    // Bytes still to follow a header: payload length plus the parity byte.
    function automatic logic [BYTE_CNT_W-1:0] pkt_bytes_after_hdr(
        input logic [HDR_LEN_W-1:0] len
    );
        return BYTE_CNT_W'(len) + BYTE_CNT_W'(1);
    endfunction

endpackage

// File: rtl/router_fifo.sv
// router_fifo
// Per-destination output FIFO of the router. Stores each byte together with
// a header tag; on readout the tag reloads a byte counter so dout can be
// forced to 0 between packets and held within a packet.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-low reset
//   soft_rst   in   synchronous flush (router FSM timeout)
//   we         in   write enable
//   lfd_state  in   byte being written is a packet header
//   din        in   byte to store
//   re         in   read enable from the destination client
//   dout       out  byte delivered to the client (1-cycle read latency)
//   full       out  no free entry
//   empty      out  no stored entry
module router_fifo
    import router_pkg::*;
#(
    parameter int DATA_W = ROUTER_DATA_W,
    parameter int DEPTH  = ROUTER_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_rst,
    input  logic              we,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]     dout_q, dout_d;
    // Low for the first edge after reset release so the first accepted
    // write lands one edge later.
    logic                  ready_q;

    logic [DATA_W:0]       mem_q [DEPTH];

    logic [AW-1:0]         wr_addr, rd_addr;
    logic [DATA_W:0]       rd_entry;
    logic                  wr_en, rd_en, flush;

    assign wr_addr  = wr_ptr_q[AW-1:0];
    assign rd_addr  = rd_ptr_q[AW-1:0];
    assign rd_entry = mem_q[rd_addr];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_addr == rd_addr) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // full/empty are pre-edge values, so a simultaneous read and write
    // resolves naturally: full drops the write, empty drops the read.
    assign flush = ready_q && soft_rst;
    assign wr_en = ready_q && !soft_rst && we && !full;
    assign rd_en = ready_q && !soft_rst && re && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            dout_d   = '0;
        end else if (ready_q) begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                dout_d   = rd_entry[DATA_W-1:0];
                if (rd_entry[DATA_W]) begin
                    cnt_d = pkt_bytes_after_hdr(
                                rd_entry[HDR_LEN_MSB:HDR_LEN_LSB]);
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - BYTE_CNT_W'(1);
                end
            end else if (cnt_q == '0) begin
                // Between packets the client sees 0; inside a packet it
                // keeps seeing the last byte until it reads again.
                dout_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            ready_q  <= 1'b1;
        end
    end

    // Storage is never cleared; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem_q[wr_addr] <= {lfd_state, din};
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_router_fifo.sv
module tb_router_fifo;

    localparam int DW  = 8;
    localparam int DEP = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          soft_rst = 1'b0;
    logic          we = 1'b0;
    logic          lfd_state = 1'b0;
    logic [DW-1:0] din = '0;
    logic          re = 1'b0;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;

    int n_cmp = 0;
    int n_err = 0;

    router_fifo #(.DATA_W(DW), .DEPTH(DEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .soft_rst  (soft_rst),
        .we        (we),
        .lfd_state (lfd_state),
        .din       (din),
        .re        (re),
        .dout      (dout),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue of {tag, byte}, a bytes-remaining count,
    // and the byte the client should currently see.
    logic [DW:0]   mq[$];
    int            m_cnt = 0;
    logic [DW-1:0] exp_dout = '0;
    bit            m_ready = 0;
    bit            m_valid = 0;

    always @(posedge clk) begin
        bit m_full, m_empty, do_rd, do_wr;
        logic [DW:0] e;
        if (!rst) begin
            mq.delete();
            m_cnt    = 0;
            exp_dout = '0;
            m_ready  = 0;
            m_valid  = 1;
        end else if (!m_ready) begin
            m_ready = 1;
        end else if (soft_rst) begin
            mq.delete();
            m_cnt    = 0;
            exp_dout = '0;
        end else begin
            m_full  = (mq.size() == DEP);
            m_empty = (mq.size() == 0);
            do_rd   = re && !m_empty;
            do_wr   = we && !m_full;
            if (do_rd) begin
                e = mq.pop_front();
                exp_dout = e[DW-1:0];
                if (e[DW])          m_cnt = int'(e[7:2]) + 1;
                else if (m_cnt > 0) m_cnt = m_cnt - 1;
            end else if (m_cnt == 0) begin
                exp_dout = '0;
            end
            if (do_wr) mq.push_back({lfd_state, din});
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_cmp++;
            if (dout !== exp_dout || full !== (mq.size() == DEP) ||
                empty !== (mq.size() == 0)) begin
                n_err++;
                $display("FAIL model_cmp t=%0t: dout=%h full=%b empty=%b required dout=%h full=%b empty=%b",
                         $time, dout, full, empty, exp_dout,
                         (mq.size() == DEP), (mq.size() == 0));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // One clock cycle with the given inputs; returns at the next negedge.
    task automatic cyc(input logic w, input logic l, input logic [DW-1:0] d,
                       input logic r, input logic s);
        we = w; lfd_state = l; din = d; re = r; soft_rst = s;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 8'h00, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        rst = 1'b1;
        idle();              // hold cycle after release
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] pkt [5];
        logic [DW-1:0] buf16 [16];
        logic [DW-1:0] wrap [45];
        pkt[0] = 8'h0E; pkt[1] = 8'hA1; pkt[2] = 8'hA2;
        pkt[3] = 8'hA3; pkt[4] = 8'h5C;

        @(negedge clk);
        idle();
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full",  32'(full),  32'd0);
        chk("reset_dout",  32'(dout),  32'd0);
        rst = 1'b1;
        idle();

        // Header + 3 payload + parity, then read it back.
        for (int i = 0; i < 5; i++) cyc(1, (i == 0), pkt[i], 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 8'h00, 1, 0);
            chk($sformatf("pkt_dout%0d", i), 32'(dout), 32'(pkt[i]));
        end
        idle();
        chk("pkt_idle_dout", 32'(dout), 32'd0);
        chk("pkt_empty", 32'(empty), 32'd1);

        // Fill to 16, drop a 17th, read back.
        for (int i = 0; i < 16; i++) begin
            buf16[i] = 8'($urandom_range(0, 254));
            cyc(1, 0, buf16[i], 0, 0);
        end
        chk("fill_full", 32'(full), 32'd1);
        cyc(1, 0, 8'hFF, 0, 0);
        chk("fill_full_after_drop", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 8'h00, 1, 0);
            chk($sformatf("fill_rd%0d", i), 32'(dout), 32'(buf16[i]));
        end
        chk("fill_drained", 32'(empty), 32'd1);

        // Simultaneous read+write while full, then while empty.
        for (int i = 0; i < 16; i++) cyc(1, 0, 8'(8'h10 + i), 0, 0);
        cyc(1, 0, 8'hFF, 1, 0);
        chk("rw_full_dout", 32'(dout), 32'h10);
        chk("rw_full_drops", 32'(full), 32'd0);
        for (int i = 1; i < 16; i++) begin
            cyc(0, 0, 8'h00, 1, 0);
            chk($sformatf("rw_full_rd%0d", i), 32'(dout), 32'(8'h10 + i));
        end
        chk("rw_full_no_ff", 32'(empty), 32'd1);
        idle();
        cyc(1, 0, 8'h77, 1, 0);
        chk("rw_empty_dout", 32'(dout), 32'd0);
        chk("rw_empty_wrote", 32'(empty), 32'd0);
        cyc(0, 0, 8'h00, 1, 0);
        chk("rw_empty_rd", 32'(dout), 32'h77);

        // Flush with 10 entries stored.
        for (int i = 0; i < 10; i++) cyc(1, 0, 8'(8'h30 + i), 0, 0);
        cyc(1, 0, 8'hEE, 1, 1);
        chk("soft_empty", 32'(empty), 32'd1);
        chk("soft_dout", 32'(dout), 32'd0);
        cyc(1, 1, 8'h08, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        chk("soft_hdr_first", 32'(dout), 32'h08);

        // Pointer wrap: 5 prefilled, then 40 simultaneous pairs.
        for (int i = 0; i < 45; i++) wrap[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 5; i++) cyc(1, 0, wrap[i], 0, 0);
        for (int i = 0; i < 40; i++) begin
            cyc(1, 0, wrap[i+5], 1, 0);
            chk($sformatf("wrap_rd%0d", i), 32'(dout), 32'(wrap[i]));
            chk($sformatf("wrap_flags%0d", i), {30'd0, full, empty}, 32'd0);
        end
        for (int i = 40; i < 45; i++) begin
            cyc(0, 0, 8'h00, 1, 0);
            chk($sformatf("wrap_tail%0d", i), 32'(dout), 32'(wrap[i]));
        end

        // Reset mid-packet after 3 of 6 bytes read.
        do_reset();
        cyc(1, 1, 8'h10, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h50 + i), 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 1, 0);
        chk("mid_dout_before", 32'(dout), 32'h51);
        rst = 1'b0;
        cyc(1, 0, 8'h99, 1, 0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_dout", 32'(dout), 32'd0);
        rst = 1'b1;
        cyc(1, 0, 8'hAA, 0, 0);
        chk("hold_write_ignored", 32'(empty), 32'd1);
        cyc(1, 0, 8'hAB, 0, 0);
        chk("post_hold_write", 32'(empty), 32'd0);
        idle();
        chk("post_rst_idle_dout", 32'(dout), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 399) != 0);
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 79) == 0));
        end
        rst = 1'b1;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
